counter_sched: RTL and testbench
================================

# counter_sched

Round-robin scheduler sharing one 8-bit up/down counter datapath between `NREQ` requesters. Each requester submits a job (direction and step count). The block grants one job at a time, drives the counter's enable and direction inputs for exactly that many cycles, then signals completion. It sits between client logic and the counter instance, which is the sole driver of the counter's `en_i`/`down_i`.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `STEPW`, default 8: width of the per-job step count.
- `clk_i`  in  1: clock, rising edge.
- `rst_ni`  in  1: asynchronous active-low reset.
- `req_i`  in  NREQ: per-requester job request, level.
- `dir_i`  in  NREQ: per-requester direction; 1 = down.
- `steps_i`  in  NREQ*STEPW: per-requester step count; requester k uses bits [k*STEPW +: STEPW].
- `gnt_o`  out  NREQ: one-hot grant, held from job start through its done cycle.
- `done_o`  out  NREQ: one-cycle completion pulse to the granted requester.
- `sat_o`  out  1: valid with `done_o`; job ended early on saturation (0 when the feature is compiled out).
- `busy_o`  out  1: high in RUN and DONE.
- `cnt_en_o`  out  1: to counter `en_i`.
- `cnt_down_o`  out  1: to counter `down_i`.
- `cnt_val_i`  in  8: current counter value, fed back from counter `val_o`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - If any `req_i` is set, pick the first set bit at or after `rr_ptr`, wrapping modulo NREQ.
  - Latch `id`, `dir_i[id]` and `steps_i[id]` into `rem`, and set `gnt_o[id]`.
  - If the latched steps == 0, go to DONE; otherwise go to RUN.
- RUN
  - `cnt_en_o` = 1 and `cnt_down_o` = latched dir; `rem` decrements each cycle.
  - When `rem` == 1, that cycle is the last step and the next state is DONE.
- DONE
  - `done_o[id]` = 1, `cnt_en_o` = 0.
  - `rr_ptr` ← (id+1) mod NREQ, `gnt_o` cleared, next state IDLE.
- `cnt_down_o` is 0 whenever not in RUN.
- Request/step inputs are sampled only in IDLE. Changes during a job are ignored.
- Requester rule: drop `req_i` the cycle after seeing `done_o`. If `req_i` is still high in a later IDLE cycle, it is a new job.
- A requester deasserting `req_i` mid-job does not abort the job.
- Simultaneous requests: the lowest index at or after `rr_ptr` wins. Others wait; no starvation, since each waits at most NREQ-1 jobs.
- Counter wrap: without the saturation feature, 255+1 → 0 and 0-1 → 255 are legal and still counted as steps.
- Reset mid-job
  - State goes to IDLE immediately; all outputs 0, `rr_ptr` = 0, `rem` = 0.
  - The partially executed job is lost; the requester must resubmit.

## Timing
- Reset values: `gnt_o`=0, `done_o`=0, `sat_o`=0, `busy_o`=0, `cnt_en_o`=0, `cnt_down_o`=0.
- Request seen in IDLE at cycle 0:
  - `gnt_o` and RUN start at cycle 1.
  - `cnt_en_o` is high in cycles 1..N.
  - `done_o` pulses at cycle N+1.
  - IDLE resumes at cycle N+2, so the earliest next grant is cycle N+3.
- steps = 0: `done_o` pulses at cycle 1 with no counter enable.
- `cnt_en_o`/`cnt_down_o` are decoded from registered state. The counter value updates at the end of each RUN cycle, so `cnt_val_i` in RUN cycle c reflects c-1 steps.

## Configuration
- `COUNTER_SCHED_SAT_EN` defined:
  - In RUN, if (dir=down and `cnt_val_i`==0) or (dir=up and `cnt_val_i`==8'hFF), `cnt_en_o` is 0 that cycle.
  - The FSM goes to DONE with `sat_o`=1 alongside `done_o`.
  - The remaining steps are discarded.
- Undefined: no saturation check, the counter wraps, and `sat_o` is tied 0.

## Structure
- Shared package `counter_sched_pkg`:
  - State enum `sched_state_e` {IDLE, RUN, DONE}.
  - `MAX_NREQ` = 8.
- One natural sub-module, `rr_arbiter`: combinational round-robin pick with inputs req and ptr, outputs one-hot grant and index. The FSM and step counter stay in the top.

## Test plan
- Single job: req0 up, steps 5, counter at 10 → `cnt_en_o` high for 5 cycles, counter 15, `done_o[0]` at cycle 6, `sat_o`=0.
- All four requesters request at once with `rr_ptr`=0 → grants served in order 0,1,2,3. Then req3 and req0 requested together → 0 is granted first (ptr wrapped to 0).
- steps = 0 on req2 → `done_o[2]` one cycle after grant; counter unchanged.
- Down job, steps 3, counter at 1:
  - Without macro: counter ends at 254, `sat_o`=0.
  - With `COUNTER_SCHED_SAT_EN`: counter stops at 0, done after 1 step, `sat_o`=1.
- `rst_ni` asserted in the 3rd RUN cycle of a 10-step job → all outputs 0 asynchronously; after release, the block returns to IDLE and re-arbitrates from ptr 0.
- Requester holds `req_i` high two cycles past done → a second identical job runs; other pending requesters are granted first if round-robin order favours them.

Source files
------------

// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the counter_sched round-robin scheduler.
package counter_sched_pkg;

    localparam int MAX_NREQ = 8;
    localparam int IDX_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    // Round-robin successor of a requester index, wrapping at nreq.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int nreq);
        logic [IDX_W-1:0] res;
        if (int'(idx) >= (nreq - 1)) begin
            res = {IDX_W{1'b0}};
        end else begin
            res = idx + {{(IDX_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer.
module rr_arbiter
    import counter_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_vld
);

    int w_j;

    // Scan all requesters starting at the pointer, wrapping modulo NREQ.
    always_comb begin
        o_gnt = {NREQ{1'b0}};
        o_idx = {IDX_W{1'b0}};
        o_vld = 1'b0;
        w_j   = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_j = int'(i_ptr) + i;
            if (w_j >= NREQ) begin
                w_j = w_j - NREQ;
            end else begin
                w_j = w_j;
            end
            if (!o_vld && i_req[w_j]) begin
                o_vld      = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = IDX_W'(w_j);
            end else begin
                o_vld = o_vld;
            end
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one 8-bit up/down counter between NREQ requesters.
// Optional build macro COUNTER_SCHED_SAT_EN stops a job early when the counter
// would wrap; without it the counter wraps freely and sat_o stays 0.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int STEPW = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    dir_i,
    input  logic [NREQ*STEPW-1:0] steps_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    done_o,
    output logic               sat_o,
    output logic               busy_o,
    output logic               cnt_en_o,
    output logic               cnt_down_o,
    input  logic [7:0]         cnt_val_i
);

    sched_state_e       r_state;
    sched_state_e       w_state_nxt;
    logic [NREQ-1:0]    r_gnt;
    logic [IDX_W-1:0]   r_id;
    logic [IDX_W-1:0]   r_ptr;
    logic               r_dir;
    logic [STEPW-1:0]   r_rem;
    logic               r_sat;

    logic [NREQ-1:0]    w_arb_gnt;
    logic [IDX_W-1:0]   w_arb_idx;
    logic               w_arb_vld;
    logic               w_sel_dir;
    logic [STEPW-1:0]   w_sel_steps;
    logic               w_sat_hit;
    logic               w_cnt_en;
    logic               w_cnt_down;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req (req_i),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_vld (w_arb_vld)
    );

    // Mux out the direction and step count of the requester the arbiter picked.
    always_comb begin
        w_sel_dir   = 1'b0;
        w_sel_steps = {STEPW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            if (w_arb_idx == IDX_W'(k)) begin
                w_sel_dir   = dir_i[k];
                w_sel_steps = steps_i[k*STEPW +: STEPW];
            end else begin
                w_sel_dir   = w_sel_dir;
            end
        end
    end

`ifdef COUNTER_SCHED_SAT_EN
    // A step would wrap the counter: down at 0 or up at 255.
    assign w_sat_hit = (r_dir && (cnt_val_i == 8'h00)) || (!r_dir && (cnt_val_i == 8'hFF));
`else
    logic w_unused_val;
    assign w_sat_hit    = 1'b0;
    assign w_unused_val = ^cnt_val_i;
`endif

    // Next-state and counter-control decode from the registered state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_en    = 1'b0;
        w_cnt_down  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_vld) begin
                    w_state_nxt = (w_sel_steps == {STEPW{1'b0}}) ? DONE : RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                w_cnt_down = r_dir;
                if (w_sat_hit) begin
                    w_cnt_en    = 1'b0;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_en    = 1'b1;
                    w_state_nxt = (r_rem == STEPW'(1)) ? DONE : RUN;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register plus job context: grant, id, direction, remaining steps, pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_gnt   <= {NREQ{1'b0}};
            r_id    <= {IDX_W{1'b0}};
            r_ptr   <= {IDX_W{1'b0}};
            r_dir   <= 1'b0;
            r_rem   <= {STEPW{1'b0}};
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_arb_vld) begin
                        r_gnt <= w_arb_gnt;
                        r_id  <= w_arb_idx;
                        r_dir <= w_sel_dir;
                        r_rem <= w_sel_steps;
                        r_sat <= 1'b0;
                    end else begin
                        r_sat <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_sat_hit) begin
                        r_sat <= 1'b1;
                    end else begin
                        r_rem <= r_rem - STEPW'(1);
                    end
                end
                DONE: begin
                    r_ptr <= rr_next(r_id, NREQ);
                    r_gnt <= {NREQ{1'b0}};
                end
                default: begin
                    r_gnt <= {NREQ{1'b0}};
                end
            endcase
        end
    end

    assign gnt_o      = r_gnt;
    assign done_o     = (r_state == DONE) ? r_gnt : {NREQ{1'b0}};
    assign sat_o      = (r_state == DONE) && r_sat;
    assign busy_o     = (r_state != IDLE);
    assign cnt_en_o   = w_cnt_en;
    assign cnt_down_o = w_cnt_down;

endmodule

// File: tb/tb_counter_sched.sv
// Scoreboard bench for counter_sched: directed jobs, expected completions queued,
// a forked monitor pops and compares at every done_o pulse.
module tb_counter_sched;

    logic        clk;
    logic        rst_ni;
    logic [3:0]  req_i;
    logic [3:0]  dir_i;
    logic [31:0] steps_i;
    logic [3:0]  gnt_o;
    logic [3:0]  done_o;
    logic        sat_o;
    logic        busy_o;
    logic        cnt_en_o;
    logic        cnt_down_o;
    logic [7:0]  cnt_val;
    logic        load_en;
    logic [7:0]  load_val;

    typedef struct {
        logic [3:0] done;
        logic       sat;
        logic [7:0] val;
        int         en;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   failures;
    int   en_cnt;

    counter_sched #(.NREQ(4), .STEPW(8)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .dir_i      (dir_i),
        .steps_i    (steps_i),
        .gnt_o      (gnt_o),
        .done_o     (done_o),
        .sat_o      (sat_o),
        .busy_o     (busy_o),
        .cnt_en_o   (cnt_en_o),
        .cnt_down_o (cnt_down_o),
        .cnt_val_i  (cnt_val)
    );

    always #5 clk = ~clk;

    // Behavioural 8-bit up/down counter driven by the scheduler.
    always @(posedge clk) begin
        if (load_en) begin
            cnt_val <= load_val;
        end else if (cnt_en_o) begin
            cnt_val <= cnt_down_o ? (cnt_val - 8'd1) : (cnt_val + 8'd1);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expect_done(input logic [3:0] d, input logic s, input logic [7:0] v, input int e);
        exp_t x;
        x.done = d; x.sat = s; x.val = v; x.en = e;
        q.push_back(x);
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                en_cnt = 0;
            end else begin
                if (cnt_en_o) en_cnt++;
                if (done_o != 4'b0000) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done actual=%b required=none", done_o);
                    end else begin
                        e = q.pop_front();
                        chk("done_vec", {28'd0, done_o}, {28'd0, e.done});
                        chk("gnt_at_done", {28'd0, gnt_o}, {28'd0, e.done});
                        chk("sat", {31'd0, sat_o}, {31'd0, e.sat});
                        chk("cnt_val", {24'd0, cnt_val}, {24'd0, e.val});
                        chk("en_cycles", en_cnt, e.en);
                    end
                    en_cnt = 0;
                end
            end
        end
    endtask

    task automatic load(input logic [7:0] v);
        @(negedge clk);
        load_en  = 1'b1;
        load_val = v;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    task automatic set_job(input int k, input logic d, input logic [7:0] s);
        dir_i[k]          = d;
        steps_i[k*8 +: 8] = s;
    endtask

    task automatic serve(input logic [3:0] reqs, input int j0, input int j1, input int j2, input int j3,
                         input bit chk_first, input logic [3:0] f_gnt, input logic f_en, input logic [3:0] f_done);
        int left[4];
        int total;
        int budget;
        left   = '{j0, j1, j2, j3};
        total  = j0 + j1 + j2 + j3;
        budget = 300;
        @(negedge clk);
        req_i = reqs;
        if (chk_first) begin
            @(posedge clk);
            #1;
            chk("first_gnt", {28'd0, gnt_o}, {28'd0, f_gnt});
            chk("first_en", {31'd0, cnt_en_o}, {31'd0, f_en});
            chk("first_done", {28'd0, done_o}, {28'd0, f_done});
        end
        while (total > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            for (int k = 0; k < 4; k++) begin
                if (done_o[k]) begin
                    left[k]--;
                    total--;
                    if (left[k] <= 0) req_i[k] = 1'b0;
                end
            end
        end
        if (total > 0) begin
            checks++;
            failures++;
            $display("FAIL serve_timeout actual=%0d_jobs_left required=0", total);
            req_i = 4'b0000;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_gnt"}, {28'd0, gnt_o}, 32'd0);
        chk({tag, "_done"}, {28'd0, done_o}, 32'd0);
        chk({tag, "_sat"}, {31'd0, sat_o}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_en"}, {31'd0, cnt_en_o}, 32'd0);
        chk({tag, "_down"}, {31'd0, cnt_down_o}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        clk      = 1'b0;
        rst_ni   = 1'b0;
        req_i    = 4'b0000;
        dir_i    = 4'b0000;
        steps_i  = 32'd0;
        load_en  = 1'b0;
        load_val = 8'd0;
        checks   = 0;
        failures = 0;
        en_cnt   = 0;
        fork
            monitor_loop();
        join_none

        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        rst_ni = 1'b1;

        // Single up job: 10 + 5 = 15.
        load(8'd10);
        set_job(0, 1'b0, 8'd5);
        expect_done(4'b0001, 1'b0, 8'd15, 5);
        serve(4'b0001, 1, 0, 0, 0, 1'b1, 4'b0001, 1'b1, 4'b0000);

        // All four at once from ptr 0: 0->2->5->4->8.
        do_reset();
        load(8'd0);
        set_job(0, 1'b0, 8'd2);
        set_job(1, 1'b0, 8'd3);
        set_job(2, 1'b1, 8'd1);
        set_job(3, 1'b0, 8'd4);
        expect_done(4'b0001, 1'b0, 8'd2, 2);
        expect_done(4'b0010, 1'b0, 8'd5, 3);
        expect_done(4'b0100, 1'b0, 8'd4, 1);
        expect_done(4'b1000, 1'b0, 8'd8, 4);
        serve(4'b1111, 1, 1, 1, 1, 1'b1, 4'b0001, 1'b1, 4'b0000);

        // req3 and req0 together, pointer wrapped to 0: 8->9->7.
        set_job(0, 1'b0, 8'd1);
        set_job(3, 1'b1, 8'd2);
        expect_done(4'b0001, 1'b0, 8'd9, 1);
        expect_done(4'b1000, 1'b0, 8'd7, 2);
        serve(4'b1001, 1, 0, 0, 1, 1'b1, 4'b0001, 1'b1, 4'b0000);

        // Zero-step job: done one cycle after grant, counter unchanged.
        set_job(2, 1'b0, 8'd0);
        expect_done(4'b0100, 1'b0, 8'd7, 0);
        serve(4'b0100, 0, 0, 1, 0, 1'b1, 4'b0100, 1'b0, 4'b0100);

        // Down 3 from 1: wraps to 254, or saturates at 0 after one step.
        load(8'd1);
        set_job(1, 1'b1, 8'd3);
`ifdef COUNTER_SCHED_SAT_EN
        expect_done(4'b0010, 1'b1, 8'd0, 1);
`else
        expect_done(4'b0010, 1'b0, 8'd254, 3);
`endif
        serve(4'b0010, 0, 1, 0, 0, 1'b1, 4'b0010, 1'b1, 4'b0000);

        // Reset in the third RUN cycle of a 10-step job.
        load(8'd0);
        set_job(0, 1'b0, 8'd10);
        @(negedge clk);
        req_i = 4'b0001;
        repeat (3) @(negedge clk);
        chk("midjob_busy", {31'd0, busy_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk_outputs_zero("async_rst");
        req_i = 4'b0000;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;

        // After reset the pointer is 0, so req1 beats req3: 20->21->22.
        load(8'd20);
        set_job(1, 1'b0, 8'd1);
        set_job(3, 1'b0, 8'd1);
        expect_done(4'b0010, 1'b0, 8'd21, 1);
        expect_done(4'b1000, 1'b0, 8'd22, 1);
        serve(4'b1010, 0, 1, 0, 1, 1'b1, 4'b0010, 1'b1, 4'b0000);

        // req2 held past done: a second identical job runs: 50->52->54.
        load(8'd50);
        set_job(2, 1'b0, 8'd2);
        expect_done(4'b0100, 1'b0, 8'd52, 2);
        expect_done(4'b0100, 1'b0, 8'd54, 2);
        serve(4'b0100, 0, 0, 2, 0, 1'b0, 4'b0000, 1'b0, 4'b0000);

        // req0 held, req1 pending: order 0,1,0 from ptr 3: 100->99->102->101.
        load(8'd100);
        set_job(0, 1'b1, 8'd1);
        set_job(1, 1'b0, 8'd3);
        expect_done(4'b0001, 1'b0, 8'd99, 1);
        expect_done(4'b0010, 1'b0, 8'd102, 3);
        expect_done(4'b0001, 1'b0, 8'd101, 1);
        serve(4'b0011, 2, 1, 0, 0, 1'b1, 4'b0001, 1'b1, 4'b0000);

        chk("queue_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
